hilo_mdu: RTL and testbench



---
 rtl/hilo_mdu.sv | 159 +++++++++++++++
 tb/tb_hilo_mdu.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
// hilo_mdu: iterative multiply/divide unit holding the architectural HI/LO
// registers. One radix-2 step per clock on a 2*XLEN accumulator.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; MTHI/MTLO writes accepted here only
// CALC   | XLEN shift-add (multiply) or restoring shift-subtract (divide)
// FINISH | sign fix-up, write HI/LO, pulse done (and div_zero)
module hilo_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            hi_we,
  input  logic            lo_we,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t            state;
  logic              is_div;
  logic              sign_a;
  logic              sign_b;
  logic              b_zero;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  // operand conditioning at launch
  logic            in_signed;
  logic            in_sa;
  logic            in_sb;
  logic [XLEN-1:0] in_amag;
  logic [XLEN-1:0] in_bmag;

  // per-iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_rem;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;

  // final fix-up
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fin_hi;
  logic [XLEN-1:0]   fin_lo;

  assign busy = (state != IDLE);

  // Magnitudes and signs of the incoming operands; unsigned ops keep signs at 0.
  always_comb begin
    in_signed = ~op[0];
    in_sa     = in_signed & src_a[XLEN-1];
    in_sb     = in_signed & src_b[XLEN-1];
    in_amag   = in_sa ? -src_a : src_a;
    in_bmag   = in_sb ? -src_b : src_b;
  end

  // One radix-2 step for both operations; the FSM picks the one in use.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    // partial remainder after the left shift needs one extra bit
    div_rem  = acc[2*XLEN-1:XLEN-1];
    div_ge   = (div_rem >= {1'b0, b_mag});
    // when div_ge holds the true difference is below b_mag, so XLEN bits suffice
    div_diff = div_rem[XLEN-1:0] - b_mag;
    div_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                      : {acc[2*XLEN-2:0], 1'b0};
  end

  // Sign correction and the divide-by-zero result that goes into HI/LO.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quot_fix = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!is_div) begin
      fin_hi = prod_fix[2*XLEN-1:XLEN];
      fin_lo = prod_fix[XLEN-1:0];
    end else if (b_zero) begin
      // re-applying the sign to the magnitude restores the original src_a
      fin_hi = sign_a ? -a_mag : a_mag;
      fin_lo = '1;
    end else begin
      fin_hi = rem_fix;
      fin_lo = quot_fix;
    end
  end

  // Control FSM, iteration counter, accumulator and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      b_zero   <= 1'b0;
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= src_a;
          if (lo_we) lo <= src_a;
          if (start) begin
            is_div <= op[1];
            sign_a <= in_sa;
            sign_b <= in_sb;
            b_zero <= (src_b == '0);
            a_mag  <= in_amag;
            b_mag  <= in_bmag;
            // dividend sits in the low half for divide, multiplier for multiply
            acc    <= {{XLEN{1'b0}}, (op[1] ? in_amag : in_bmag)};
            cnt    <= CNT_LAST;
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt == '0) state <= FINISH;
          else           cnt   <= cnt - 1'b1;
        end
        FINISH: begin
          hi       <= fin_hi;
          lo       <= fin_lo;
          done     <= 1'b1;
          div_zero <= is_div & b_zero;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: scoreboard bench for hilo_mdu. Expected HI/LO/div_zero are
// pushed when an operation is launched and popped when done is seen.
module tb_hilo_mdu;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  typedef struct packed {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
  } vec_t;

  exp_t sb_q[$];

  hilo_mdu #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference behaviour built from plain SystemVerilog arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] p;
    logic [63:0] u;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    e = '0;
    sa = a;
    sb = b;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    case (o)
      2'd0: begin p = sa64 * sb64; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin u = {32'b0, a} * {32'b0, b}; e.hi = u[63:32]; e.lo = u[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else if (o == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.hi = 32'd0; e.lo = 32'h8000_0000;
        end else if (o == 2'd2) begin
          e.lo = sa / sb; e.hi = sa % sb;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Drive a start pulse sampled at the next rising edge; returns #1 after it.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges and busy cycles until done rises (bounded).
  task automatic wait_done(output int edges, output int busy_cnt, output logic seen);
    edges = 0; busy_cnt = 0; seen = 1'b0;
    while (edges < 100) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, div_zero} !== 3'b000)
      begin failures++; $display("FAIL reset_flags got %b want 000", {busy, done, div_zero}); end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0)
      begin failures++; $display("FAIL reset_hilo got hi=%h lo=%h want 0/0", hi, lo); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_table();
    vec_t tbl[8];
    exp_t e;
    int ed, bc;
    logic seen;
    tbl[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1] = '{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    tbl[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    tbl[5] = '{2'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    tbl[6] = '{2'd2, 32'hFFFF_FF00, 32'd0,         32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1};
    tbl[7] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back('{tbl[i].h, tbl[i].l, tbl[i].dz});
      launch(tbl[i].o, tbl[i].a, tbl[i].b);
      wait_done(ed, bc, seen);
      checks++;
      if (!seen || ed != 33)
        begin failures++; $display("FAIL tbl%0d_latency got seen=%0b edges=%0d want 33", i, seen, ed); end
      checks++;
      if (bc != 33)
        begin failures++; $display("FAIL tbl%0d_busy got %0d cycles want 33", i, bc); end
      e = sb_q.pop_front();
      checks++;
      if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz})
        begin failures++; $display("FAIL tbl%0d_result got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b", i, hi, lo, div_zero, e.hi, e.lo, e.dz); end
      @(posedge clk); #1;
      checks++;
      if ({done, div_zero} !== 2'b00 || hi !== e.hi || lo !== e.lo)
        begin failures++; $display("FAIL tbl%0d_pulse got done=%b dz=%b hi=%h lo=%h", i, done, div_zero, hi, lo); end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int ed, bc;
    logic seen;
    logic [1:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      sb_q.push_back(model(o, a, b));
      launch(o, a, b);
      wait_done(ed, bc, seen);
      checks++;
      if (!seen || ed != 33)
        begin failures++; $display("FAIL rnd%0d_latency got seen=%0b edges=%0d want 33", i, seen, ed); end
      e = sb_q.pop_front();
      checks++;
      if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz})
        begin failures++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b", i, o, a, b, hi, lo, div_zero, e.hi, e.lo, e.dz); end
    end
  endtask

  task automatic test_mthi_mtlo();
    exp_t e;
    int ed, bc;
    logic seen;
    @(negedge clk);
    src_a = 32'hAAAA_5555; hi_we = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'hAAAA_5555)
      begin failures++; $display("FAIL mthi got %h want aaaa5555", hi); end
    @(negedge clk);
    src_a = 32'h0F0F_0F0F; lo_we = 1'b1;
    @(posedge clk); #1;
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'h0F0F_0F0F || hi !== 32'hAAAA_5555)
      begin failures++; $display("FAIL mtlo got hi=%h lo=%h want aaaa5555/0f0f0f0f", hi, lo); end
    // both writes together with a start: write lands, result overwrites later
    @(negedge clk);
    op = 2'd1; src_a = 32'd3; src_b = 32'd4; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
    sb_q.push_back('{32'd0, 32'd12, 1'b0});
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'd3 || lo !== 32'd3 || busy !== 1'b1)
      begin failures++; $display("FAIL mt_with_start got hi=%h lo=%h busy=%b want 3/3/1", hi, lo, busy); end
    wait_done(ed, bc, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || ed != 33 || hi !== e.hi || lo !== e.lo)
      begin failures++; $display("FAIL mt_overwrite got edges=%0d hi=%h lo=%h want 33 hi=%h lo=%h", ed, hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_busy_writes();
    exp_t e;
    int ed, bc;
    logic seen;
    @(negedge clk);
    src_a = 32'hAAAA_5555; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0; src_a = 32'h0F0F_0F0F; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    sb_q.push_back(model(2'd1, 32'd6, 32'd7));
    launch(2'd1, 32'd6, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    src_a = 32'hDEAD_BEEF; hi_we = 1'b1; lo_we = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'hAAAA_5555 || lo !== 32'h0F0F_0F0F)
      begin failures++; $display("FAIL busy_write got hi=%h lo=%h want aaaa5555/0f0f0f0f", hi, lo); end
    wait_done(ed, bc, seen);
    checks++;
    if (!seen || ed != 29 || bc != 29)
      begin failures++; $display("FAIL busy_write_latency got edges=%0d busy=%0d want 29/29", ed, bc); end
    e = sb_q.pop_front();
    checks++;
    if (hi !== e.hi || lo !== e.lo)
      begin failures++; $display("FAIL busy_write_result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    int dcount;
    int first;
    dcount = 0; first = -1;
    sb_q.push_back(model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0));
    launch(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin op = 2'd0; src_a = 32'd1; src_b = 32'd2; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done) begin dcount++; if (first < 0) first = i; end
    end
    start = 1'b0;
    checks++;
    if (dcount != 1 || first != 33)
      begin failures++; $display("FAIL start_ignored got dones=%0d first_edge=%0d want 1/33", dcount, first); end
    e = sb_q.pop_front();
    checks++;
    if (hi !== e.hi || lo !== e.lo)
      begin failures++; $display("FAIL start_ignored_result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int ed, bc;
    logic seen;
    launch(2'd1, 32'hFFFF_FFFF, 32'd2);
    repeat (9) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00)
      begin failures++; $display("FAIL reset_mid_flags got busy=%b done=%b want 0/0", busy, done); end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0)
      begin failures++; $display("FAIL reset_mid_hilo got hi=%h lo=%h want 0/0", hi, lo); end
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.push_back('{32'd0, 32'd15, 1'b0});
    launch(2'd1, 32'd3, 32'd5);
    wait_done(ed, bc, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || ed != 33 || hi !== e.hi || lo !== e.lo || div_zero !== 1'b0)
      begin failures++; $display("FAIL reset_mid_fresh got edges=%0d hi=%h lo=%h dz=%b want 33 hi=%h lo=%h dz=0", ed, hi, lo, div_zero, e.hi, e.lo); end
  endtask

  initial begin
    test_reset();
    test_table();
    test_random();
    test_mthi_mtlo();
    test_busy_writes();
    test_start_ignored();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0)
      begin failures++; $display("FAIL scoreboard_left got %0d entries want 0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
